// File: rtl/drop_pkg.sv
// Shared slot-state type and width helpers for the multi-object drop engine.
package drop_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FALL = 1'b1
    } slot_state_e;

    // Bits needed to index n items, never less than one.
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Bits needed to hold a count from 0 to n inclusive.
    function automatic int count_width(input int n);
        return width_of(n + 1);
    endfunction

endpackage

// File: rtl/drop_slot.sv
// One falling-object slot: IDLE/FALL state, frame divider, row stepping and
// catch/miss resolution on the bottom row.
module drop_slot
    import drop_pkg::*;
#(
    parameter int COLS = 8,
    parameter int ROWS = 8,
    parameter int PW   = 4
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      load,
    input  logic [width_of(COLS)-1:0] load_col,
    input  logic                      advance,
    input  logic [PW-1:0]             eff_period,
    input  logic [width_of(COLS)-1:0] player_col,
    output logic                      busy,
    output logic [width_of(COLS)-1:0] col,
    output logic [width_of(ROWS)-1:0] row,
    output logic                      is_catch,
    output logic                      is_miss
);

    localparam int CW = width_of(COLS);
    localparam int RW = width_of(ROWS);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    typedef struct packed {
        slot_state_e   state;
        logic [CW-1:0] col;
        logic [RW-1:0] row;
        logic [PW-1:0] div;
    } slot_t;

    slot_t cur, nxt;

    // NOTE: registered state uses non-blocking assignments; the combinational
    // next-state block below uses blocking ones.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            cur.state <= S_IDLE;
            cur.col   <= '0;
            cur.row   <= '0;
            cur.div   <= '0;
        end else begin
            cur <= nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        nxt      = cur;
        is_catch = 1'b0;
        is_miss  = 1'b0;
        case (cur.state)
            S_IDLE: begin
                if (load) begin
                    nxt.state = S_FALL;
                    nxt.col   = load_col;
                    nxt.row   = '0;
                    nxt.div   = '0;
                end
            end
            S_FALL: begin
                if (advance) begin
                    if (cur.div == eff_period - PW'(1)) begin
                        nxt.div = '0;
                        if (cur.row == LAST_ROW) begin
                            nxt.state = S_IDLE;
                            is_catch  = (cur.col == player_col);
                            is_miss   = (cur.col != player_col);
                        end else begin
                            nxt.row = cur.row + RW'(1);
                        end
                    end else begin
                        nxt.div = cur.div + PW'(1);
                    end
                end
            end
            default: nxt = cur;
        endcase
    end

    assign busy = (cur.state == S_FALL);
    assign col  = cur.col;
    assign row  = cur.row;

endmodule

// File: rtl/multi_drop_engine.sv
// Multi-object falling engine for the LED catch game: slot allocation, score,
// miss counting, game-over and the occupancy map. DROP_SPEEDUP_EN shortens the
// fall period as the score grows.
module multi_drop_engine
    import drop_pkg::*;
#(
    parameter int COLS         = 8,
    parameter int ROWS         = 8,
    parameter int N_OBJ        = 4,
    parameter int PW           = 4,
    parameter int SW           = 8,
    parameter int MAX_MISS     = 3,
    parameter int SPEEDUP_STEP = 4
) (
    input  logic                             clock,
    input  logic                             resetn,
    input  logic                             tick,
    input  logic                             spawn_valid,
    input  logic [width_of(COLS)-1:0]        spawn_col,
    output logic                             spawn_ready,
    input  logic [width_of(COLS)-1:0]        player_col,
    input  logic [PW-1:0]                    fall_period,
    output logic [COLS*ROWS-1:0]             obj_map,
    output logic                             catch_pulse,
    output logic                             miss_pulse,
    output logic [SW-1:0]                    score,
    output logic [count_width(MAX_MISS)-1:0] miss_cnt,
    output logic                             lose,
    output logic                             frame_done
);

    localparam int CW    = width_of(COLS);
    localparam int RW    = width_of(ROWS);
    localparam int MW    = count_width(MAX_MISS);
    localparam int NW    = count_width(N_OBJ);
    localparam int MAP_W = COLS * ROWS;

    logic             accept;
    logic             spawn_fire;
    logic [CW-1:0]    load_col;
    logic [PW-1:0]    eff_period;
    logic [N_OBJ-1:0] busy, load, is_catch, is_miss;
    logic [CW-1:0]    slot_col [N_OBJ];
    logic [RW-1:0]    slot_row [N_OBJ];
    logic [NW-1:0]    n_catch, n_miss;
    logic [SW-1:0]    score_nxt;
    logic [MW-1:0]    miss_nxt;

    assign accept      = tick && !lose;
    assign spawn_ready = !(&busy) && !lose;
    assign spawn_fire  = spawn_valid && spawn_ready;
    assign load_col    = (int'(spawn_col) >= COLS) ? CW'(COLS - 1) : spawn_col;

    // Lowest-index idle slot takes the new object.
    always_comb begin : alloc
        logic found;
        found = 1'b0;
        load  = '0;
        for (int i = 0; i < N_OBJ; i++) begin
            if (!found && !busy[i]) begin
                load[i] = spawn_fire;
                found   = 1'b1;
            end
        end
    end

`ifdef DROP_SPEEDUP_EN
    always_comb begin : speedup
        logic [PW:0]   fp;
        logic [SW-1:0] quot;
        fp   = (fall_period == '0) ? (PW+1)'(1) : {1'b0, fall_period};
        quot = score / SW'(SPEEDUP_STEP);
        if (int'(quot) >= int'(fp)) eff_period = PW'(1);
        else                        eff_period = PW'(fp - (PW+1)'(quot));
    end
`else
    assign eff_period = (fall_period == '0) ? PW'(1) : fall_period;
    logic unused_speedup;
    assign unused_speedup = ^SPEEDUP_STEP;
`endif

    for (genvar g = 0; g < N_OBJ; g++) begin : g_slot
        drop_slot #(.COLS(COLS), .ROWS(ROWS), .PW(PW)) u_slot (
            .clock      (clock),
            .resetn     (resetn),
            .load       (load[g]),
            .load_col   (load_col),
            .advance    (accept),
            .eff_period (eff_period),
            .player_col (player_col),
            .busy       (busy[g]),
            .col        (slot_col[g]),
            .row        (slot_row[g]),
            .is_catch   (is_catch[g]),
            .is_miss    (is_miss[g])
        );
    end

    always_comb begin
        obj_map = '0;
        n_catch = '0;
        n_miss  = '0;
        for (int i = 0; i < N_OBJ; i++) begin
            if (busy[i])
                obj_map = obj_map | (MAP_W'(1) << (int'(slot_row[i]) * COLS + int'(slot_col[i])));
            n_catch = n_catch + NW'(is_catch[i]);
            n_miss  = n_miss + NW'(is_miss[i]);
        end
    end

    // Saturating next values for score and miss count.
    always_comb begin : sat
        logic [SW:0]      score_sum;
        logic [MW+NW-1:0] miss_sum;
        score_sum = {1'b0, score} + (SW+1)'(n_catch);
        score_nxt = score_sum[SW] ? '1 : score_sum[SW-1:0];
        miss_sum  = (MW+NW)'(miss_cnt) + (MW+NW)'(n_miss);
        miss_nxt  = (miss_sum >= (MW+NW)'(MAX_MISS)) ? MW'(MAX_MISS) : miss_sum[MW-1:0];
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            score       <= '0;
            miss_cnt    <= '0;
            lose        <= 1'b0;
            catch_pulse <= 1'b0;
            miss_pulse  <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            catch_pulse <= |is_catch;
            miss_pulse  <= |is_miss;
            frame_done  <= accept;
            if (accept) begin
                score    <= score_nxt;
                miss_cnt <= miss_nxt;
                if (miss_nxt >= MW'(MAX_MISS)) lose <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multi_drop_engine.sv
// Self-checking bench for multi_drop_engine: directed scenarios plus randomized
// traffic against a queue-based model of the game rules.
module tb_multi_drop_engine;

    localparam int COLS = 8, ROWS = 8, N_OBJ = 4, PW = 4, SW = 8;
    localparam int MAX_MISS = 3, SPEEDUP_STEP = 4;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        tick = 1'b0;
    logic        spawn_valid = 1'b0;
    logic [2:0]  spawn_col = '0;
    logic        spawn_ready;
    logic [2:0]  player_col = '0;
    logic [3:0]  fall_period = 4'd1;
    logic [63:0] obj_map;
    logic        catch_pulse, miss_pulse, lose, frame_done;
    logic [7:0]  score;
    logic [1:0]  miss_cnt;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    multi_drop_engine #(
        .COLS(COLS), .ROWS(ROWS), .N_OBJ(N_OBJ), .PW(PW), .SW(SW),
        .MAX_MISS(MAX_MISS), .SPEEDUP_STEP(SPEEDUP_STEP)
    ) dut (
        .clock(clock), .resetn(resetn), .tick(tick), .spawn_valid(spawn_valid),
        .spawn_col(spawn_col), .spawn_ready(spawn_ready), .player_col(player_col),
        .fall_period(fall_period), .obj_map(obj_map), .catch_pulse(catch_pulse),
        .miss_pulse(miss_pulse), .score(score), .miss_cnt(miss_cnt), .lose(lose),
        .frame_done(frame_done)
    );

    // Reference model: a bag of falling objects plus game counters.
    typedef struct { int col; int row; int div; } obj_t;
    obj_t objs[$];
    int   m_score = 0, m_miss = 0;
    bit   m_lose = 0, m_catch_p = 0, m_miss_p = 0, m_frame = 0;

    function automatic int eff_period_f();
        int fp;
        fp = (fall_period == 0) ? 1 : int'(fall_period);
`ifdef DROP_SPEEDUP_EN
        if (m_score / SPEEDUP_STEP >= fp) return 1;
        return fp - m_score / SPEEDUP_STEP;
`else
        return fp;
`endif
    endfunction

    function automatic logic [63:0] model_map();
        logic [63:0] m;
        m = '0;
        foreach (objs[i]) m[objs[i].row * COLS + objs[i].col] = 1'b1;
        return m;
    endfunction

    // Apply one clock of the rules to the model, then let the DUT take the edge.
    task automatic cycle();
        int nc, nm, e;
        bit rdy, acc;
        obj_t keep[$];
        obj_t o;
        nc = 0;
        nm = 0;
        if (!resetn) begin
            objs.delete();
            m_score = 0; m_miss = 0; m_lose = 0;
            m_catch_p = 0; m_miss_p = 0; m_frame = 0;
        end else begin
            rdy = (objs.size() < N_OBJ) && !m_lose;
            acc = tick && !m_lose;
            e   = eff_period_f();
            if (acc) begin
                foreach (objs[i]) begin
                    o = objs[i];
                    if (o.div == e - 1) begin
                        o.div = 0;
                        if (o.row == ROWS - 1) begin
                            if (o.col == int'(player_col)) nc++;
                            else nm++;
                            continue;
                        end
                        o.row++;
                    end else begin
                        o.div = (o.div + 1) % 16;
                    end
                    keep.push_back(o);
                end
                objs = keep;
            end
            if (spawn_valid && rdy) begin
                o.col = (int'(spawn_col) >= COLS) ? COLS - 1 : int'(spawn_col);
                o.row = 0;
                o.div = 0;
                objs.push_back(o);
            end
            m_catch_p = (nc > 0);
            m_miss_p  = (nm > 0);
            m_frame   = acc;
            m_score   = (m_score + nc > 255) ? 255 : m_score + nc;
            m_miss    = (m_miss + nm > MAX_MISS) ? MAX_MISS : m_miss + nm;
            if (m_miss >= MAX_MISS) m_lose = 1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit sv, input int col, input bit tk);
        spawn_valid = sv;
        spawn_col   = 3'(col);
        tick        = tk;
        cycle();
        spawn_valid = 1'b0;
        tick        = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; spawn_valid = 1'b1; tick = 1'b1; spawn_col = 3'd3;
        cycle();
        cycle();
        n_cmp++; if (obj_map !== 64'd0) begin n_fail++; $display("FAIL reset_map: got %h want 0", obj_map); end
        n_cmp++; if (score !== 8'd0 || miss_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_counters: score %0d miss %0d want 0 0", score, miss_cnt); end
        n_cmp++; if ({lose, catch_pulse, miss_pulse, frame_done} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {lose, catch_pulse, miss_pulse, frame_done}); end
        n_cmp++; if (spawn_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", spawn_ready); end
        resetn = 1'b1; spawn_valid = 1'b0; tick = 1'b0;
    endtask

    task automatic test_catch();
        int pulses;
        pulses = 0;
        fall_period = 4'd1; player_col = 3'd3;
        drive(1, 3, 0);
        n_cmp++; if (obj_map !== (64'd1 << 3)) begin n_fail++; $display("FAIL catch_spawn_vis: got %h want %h", obj_map, 64'd1 << 3); end
        for (int k = 0; k < 7; k++) begin
            drive(0, 0, 1);
            pulses += int'(catch_pulse);
        end
        n_cmp++; if (obj_map !== (64'd1 << 59)) begin n_fail++; $display("FAIL catch_bottom: got %h want %h", obj_map, 64'd1 << 59); end
        drive(0, 0, 1);
        pulses += int'(catch_pulse);
        n_cmp++; if (catch_pulse !== 1'b1 || miss_pulse !== 1'b0 || frame_done !== 1'b1) begin n_fail++; $display("FAIL catch_pulses: catch %b miss %b frame %b want 1 0 1", catch_pulse, miss_pulse, frame_done); end
        n_cmp++; if (score !== 8'd1) begin n_fail++; $display("FAIL catch_score: got %0d want 1", score); end
        n_cmp++; if (obj_map !== 64'd0 || spawn_ready !== 1'b1) begin n_fail++; $display("FAIL catch_freed: map %h ready %b want 0 1", obj_map, spawn_ready); end
        drive(0, 0, 0);
        pulses += int'(catch_pulse);
        n_cmp++; if (pulses != 1) begin n_fail++; $display("FAIL catch_once: got %0d pulses want 1", pulses); end
    endtask

    task automatic test_reset_mid_fall();
        drive(1, 1, 0);
        drive(1, 6, 1);
        for (int k = 0; k < 3; k++) drive(0, 0, 1);
        n_cmp++; if (obj_map !== ((64'd1 << 33) | (64'd1 << 30))) begin n_fail++; $display("FAIL midfall_map: got %h want %h", obj_map, (64'd1 << 33) | (64'd1 << 30)); end
        resetn = 1'b0;
        drive(1, 2, 1);
        resetn = 1'b1;
        n_cmp++; if (obj_map !== 64'd0 || score !== 8'd0 || lose !== 1'b0 || spawn_ready !== 1'b1) begin n_fail++; $display("FAIL midfall_reset: map %h score %0d lose %b ready %b want 0 0 0 1", obj_map, score, lose, spawn_ready); end
    endtask

    task automatic test_miss_lose();
        int pulses, n;
        logic [63:0] frozen;
        do_reset();
        fall_period = 4'd1; player_col = 3'd5;
        pulses = 0;
        for (int k = 0; k < 4; k++) drive(1, (k == 3) ? 1 : 0, 1);
        n = 0;
        while (!lose && n < 30) begin
            drive(0, 0, 1);
            pulses += int'(miss_pulse);
            n++;
        end
        n_cmp++; if (lose !== 1'b1) begin n_fail++; $display("FAIL lose_timeout: lose %b after %0d ticks want 1", lose, n); end
        n_cmp++; if (miss_cnt !== 2'd3 || pulses != 3) begin n_fail++; $display("FAIL lose_misses: miss_cnt %0d pulses %0d want 3 3", miss_cnt, pulses); end
        n_cmp++; if (spawn_ready !== 1'b0) begin n_fail++; $display("FAIL lose_ready: got %b want 0", spawn_ready); end
        n_cmp++; if (obj_map !== (64'd1 << 57)) begin n_fail++; $display("FAIL lose_frozen: got %h want %h", obj_map, 64'd1 << 57); end
        frozen = obj_map;
        for (int k = 0; k < 5; k++) drive(1, 4, 1);
        n_cmp++; if (obj_map !== frozen || frame_done !== 1'b0 || miss_cnt !== 2'd3 || lose !== 1'b1) begin n_fail++; $display("FAIL lose_hold: map %h frame %b miss %0d lose %b want %h 0 3 1", obj_map, frame_done, miss_cnt, lose, frozen); end
    endtask

    task automatic test_full_simultaneous();
        logic [63:0] exp_map;
        do_reset();
        fall_period = 4'd1; player_col = 3'd2;
        drive(1, 2, 0);
        drive(1, 4, 0);
        drive(1, 5, 1);
        drive(1, 5, 1);
        n_cmp++; if (spawn_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", spawn_ready); end
        drive(1, 1, 0);
        exp_map = (64'd1 << 18) | (64'd1 << 20) | (64'd1 << 13) | (64'd1 << 5);
        n_cmp++; if (obj_map !== exp_map) begin n_fail++; $display("FAIL full_reject: got %h want %h", obj_map, exp_map); end
        for (int k = 0; k < 6; k++) drive(0, 0, 1);
        n_cmp++; if (catch_pulse !== 1'b1 || miss_pulse !== 1'b1) begin n_fail++; $display("FAIL simul_pulses: catch %b miss %b want 1 1", catch_pulse, miss_pulse); end
        n_cmp++; if (score !== 8'd1 || miss_cnt !== 2'd1 || lose !== 1'b0) begin n_fail++; $display("FAIL simul_counts: score %0d miss %0d lose %b want 1 1 0", score, miss_cnt, lose); end
        exp_map = (64'd1 << 61) | (64'd1 << 53);
        n_cmp++; if (obj_map !== exp_map || spawn_ready !== 1'b1) begin n_fail++; $display("FAIL simul_map: map %h ready %b want %h 1", obj_map, spawn_ready, exp_map); end
    endtask

    task automatic test_period();
        logic [63:0] exp_map;
        do_reset();
        fall_period = 4'd3; player_col = 3'd0;
        drive(1, 0, 0);
        for (int k = 1; k <= 9; k++) begin
            drive(0, 0, 1);
            exp_map = 64'd1 << (8 * (k / 3));
            n_cmp++; if (obj_map !== exp_map) begin n_fail++; $display("FAIL period3_tick%0d: got %h want %h", k, obj_map, exp_map); end
        end
        do_reset();
        fall_period = 4'd0;
        drive(1, 1, 0);
        for (int k = 0; k < 3; k++) drive(0, 0, 1);
        n_cmp++; if (obj_map !== (64'd1 << 25)) begin n_fail++; $display("FAIL period0: got %h want %h", obj_map, 64'd1 << 25); end
        drive(1, 7, 1);
        exp_map = (64'd1 << 33) | (64'd1 << 7);
        n_cmp++; if (obj_map !== exp_map) begin n_fail++; $display("FAIL spawn_on_tick: got %h want %h", obj_map, exp_map); end
    endtask

`ifdef DROP_SPEEDUP_EN
    task automatic catch_one();
        int n;
        drive(1, 0, 0);
        n = 0;
        while (n < 100) begin
            drive(0, 0, 1);
            n++;
            if (catch_pulse) break;
        end
        n_cmp++; if (catch_pulse !== 1'b1) begin n_fail++; $display("FAIL speedup_catch_timeout: no catch after %0d ticks", n); end
    endtask

    task automatic measure_step(input int want);
        int n;
        drive(1, 0, 0);
        n = 0;
        while (obj_map !== (64'd1 << 8) && n < 50) begin
            drive(0, 0, 1);
            n++;
        end
        n_cmp++; if (n != want) begin n_fail++; $display("FAIL speedup_step score %0d: got %0d ticks want %0d", score, n, want); end
        while (!catch_pulse && n < 200) begin
            drive(0, 0, 1);
            n++;
        end
    endtask

    task automatic test_speedup();
        do_reset();
        fall_period = 4'd4; player_col = 3'd0;
        while (score < 8'd4 && !lose) catch_one();
        measure_step(3);
        while (score < 8'd16 && !lose) catch_one();
        measure_step(1);
    endtask
`endif

    task automatic test_random();
        for (int ph = 0; ph < 4; ph++) begin
            do_reset();
            fall_period = 4'($urandom_range(0, 3));
            player_col  = 3'($urandom_range(0, 1));
            for (int c = 0; c < 300; c++) begin
                if (c % 100 == 99) fall_period = 4'($urandom_range(0, 3));
                if (c % 25 == 24) player_col = 3'($urandom_range(0, 1));
                spawn_valid = ($urandom_range(0, 2) == 0);
                spawn_col   = (ph % 2 == 0) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
                tick        = ($urandom_range(0, 1) == 1);
                cycle();
                n_cmp++; if (obj_map !== model_map()) begin n_fail++; $display("FAIL rand_map ph%0d c%0d: got %h want %h", ph, c, obj_map, model_map()); end
                n_cmp++; if (score !== 8'(m_score)) begin n_fail++; $display("FAIL rand_score ph%0d c%0d: got %0d want %0d", ph, c, score, m_score); end
                n_cmp++; if (miss_cnt !== 2'(m_miss)) begin n_fail++; $display("FAIL rand_miss ph%0d c%0d: got %0d want %0d", ph, c, miss_cnt, m_miss); end
                n_cmp++; if (lose !== m_lose) begin n_fail++; $display("FAIL rand_lose ph%0d c%0d: got %b want %b", ph, c, lose, m_lose); end
                n_cmp++; if (spawn_ready !== ((objs.size() < N_OBJ) && !m_lose)) begin n_fail++; $display("FAIL rand_ready ph%0d c%0d: got %b want %b", ph, c, spawn_ready, (objs.size() < N_OBJ) && !m_lose); end
                n_cmp++; if ({catch_pulse, miss_pulse, frame_done} !== {m_catch_p, m_miss_p, m_frame}) begin n_fail++; $display("FAIL rand_pulses ph%0d c%0d: got %b want %b", ph, c, {catch_pulse, miss_pulse, frame_done}, {m_catch_p, m_miss_p, m_frame}); end
            end
            spawn_valid = 1'b0;
            tick = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_catch();
        test_reset_mid_fall();
        test_miss_lose();
        test_full_simultaneous();
        test_period();
`ifdef DROP_SPEEDUP_EN
        test_speedup();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
